// File: rtl/key_search_sequencer.sv
// Brute-force key-space controller: steps time_machine through candidate keys until a valid message or range end.
// Optional per-key watchdog and timed_out port enabled by defining KEY_SEARCH_TIMEOUT_EN.
module key_search_sequencer #(
  parameter int unsigned          KEY_WIDTH      = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_START      = '0,
  parameter logic [KEY_WIDTH-1:0] KEY_END        = KEY_WIDTH'(24'h3FFFFF),
  parameter int unsigned          SETTLE_CYCLES  = 2
`ifdef KEY_SEARCH_TIMEOUT_EN
  ,
  parameter logic [19:0]          TIMEOUT_CYCLES = 20'hFFFFF
`endif
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 decrypt_done,
  input  logic                 msg_valid,
  output logic [KEY_WIDTH-1:0] secret_key,
  output logic                 key_changed,
  output logic                 key_available,
  output logic                 busy,
  output logic                 found,
  output logic                 exhausted,
`ifdef KEY_SEARCH_TIMEOUT_EN
  output logic                 timed_out,
`endif
  output logic [KEY_WIDTH-1:0] keys_tried
);

  localparam int unsigned SETTLE_W    = 4;
  localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, SETTLE, RUN, CHECK, FOUND, EXHAUSTED, TIMED_OUT
  } state_t;

  state_t                r_state, w_next;
  logic                  r_start_q, r_done_q;
  logic [SETTLE_W-1:0]   r_settle, w_settle_next;
  logic                  r_msg_valid, w_msg_valid_next;
  logic [KEY_WIDTH-1:0]  w_key_next, w_tried_next;
  logic                  w_start_edge, w_done_edge;
`ifdef KEY_SEARCH_TIMEOUT_EN
  logic [19:0]           r_wdog, w_wdog_next;
`endif

  assign w_start_edge = start & ~r_start_q;
  assign w_done_edge  = decrypt_done & ~r_done_q;

  // Next-state, settle counter, key and tally updates
  always_comb begin
    w_next           = r_state;
    w_settle_next    = r_settle;
    w_msg_valid_next = r_msg_valid;
    w_key_next       = secret_key;
    w_tried_next     = keys_tried;
`ifdef KEY_SEARCH_TIMEOUT_EN
    w_wdog_next      = '0;
`endif
    case (r_state)
      IDLE, FOUND, EXHAUSTED, TIMED_OUT: begin
        if (w_start_edge) begin
          w_next       = LOAD;
          w_key_next   = KEY_START;
          w_tried_next = '0;
        end
      end
      LOAD: begin
        w_settle_next = SETTLE_INIT;
        w_next        = (SETTLE_INIT == '0) ? RUN : SETTLE;
      end
      SETTLE: begin
        w_settle_next = r_settle - SETTLE_W'(1);
        if (r_settle <= SETTLE_W'(1)) w_next = RUN;
      end
      RUN: begin
        if (w_done_edge) begin
          w_next           = CHECK;
          w_msg_valid_next = msg_valid;
        end
`ifdef KEY_SEARCH_TIMEOUT_EN
        else if (r_wdog == TIMEOUT_CYCLES - 20'd1) begin
          w_next = TIMED_OUT;
        end else begin
          w_wdog_next = r_wdog + 20'd1;
        end
`endif
      end
      CHECK: begin
        w_tried_next = keys_tried + KEY_WIDTH'(1);
        if (r_msg_valid)              w_next = FOUND;
        else if (secret_key == KEY_END) w_next = EXHAUSTED;
        else begin
          w_key_next = secret_key + KEY_WIDTH'(1);
          w_next     = LOAD;
        end
      end
      default: w_next = IDLE;
    endcase
    // Abort overrides everything, including a pending CHECK update
    if (abort) begin
      w_next       = IDLE;
      w_key_next   = secret_key;
      w_tried_next = keys_tried;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_start_q     <= 1'b0;
      r_done_q      <= 1'b0;
      r_settle      <= '0;
      r_msg_valid   <= 1'b0;
      secret_key    <= KEY_START;
      keys_tried    <= '0;
      key_changed   <= 1'b0;
      key_available <= 1'b0;
      busy          <= 1'b0;
      found         <= 1'b0;
      exhausted     <= 1'b0;
`ifdef KEY_SEARCH_TIMEOUT_EN
      r_wdog        <= '0;
      timed_out     <= 1'b0;
`endif
    end else begin
      r_state       <= w_next;
      r_start_q     <= start;
      r_done_q      <= decrypt_done;
      r_settle      <= w_settle_next;
      r_msg_valid   <= w_msg_valid_next;
      secret_key    <= w_key_next;
      keys_tried    <= w_tried_next;
      key_changed   <= (w_next == LOAD);
      key_available <= (w_next == RUN);
      busy          <= (w_next == LOAD) || (w_next == SETTLE) ||
                       (w_next == RUN)  || (w_next == CHECK);
      found         <= (w_next == FOUND);
      exhausted     <= (w_next == EXHAUSTED);
`ifdef KEY_SEARCH_TIMEOUT_EN
      r_wdog        <= w_wdog_next;
      timed_out     <= (w_next == TIMED_OUT);
`endif
    end
  end

endmodule

// File: tb/tb_key_search_sequencer.sv
// Bench for key_search_sequencer: directed scenarios plus random stimulus against a behavioural model.
// Builds with or without KEY_SEARCH_TIMEOUT_EN.
module tb_key_search_sequencer;

  localparam int unsigned KW = 8;
  localparam logic [KW-1:0] KS = 8'd0;
  localparam logic [KW-1:0] KE = 8'd3;
  localparam int S = 2;
`ifdef KEY_SEARCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TO = 100;

  logic CLOCK_50 = 1'b0;
  logic reset = 1'b0, start = 1'b0, abort = 1'b0, decrypt_done = 1'b0, msg_valid = 1'b0;
  logic [KW-1:0] secret_key, keys_tried;
  logic key_changed, key_available, busy, found, exhausted;
  logic timed_out_w;

  int checks = 0;
  int failures = 0;
  int kc_count = 0;

  key_search_sequencer #(
    .KEY_WIDTH(KW), .KEY_START(KS), .KEY_END(KE), .SETTLE_CYCLES(S)
`ifdef KEY_SEARCH_TIMEOUT_EN
    , .TIMEOUT_CYCLES(20'(TO))
`endif
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .abort(abort),
    .decrypt_done(decrypt_done), .msg_valid(msg_valid),
    .secret_key(secret_key), .key_changed(key_changed), .key_available(key_available),
    .busy(busy), .found(found), .exhausted(exhausted),
`ifdef KEY_SEARCH_TIMEOUT_EN
    .timed_out(timed_out_w),
`endif
    .keys_tried(keys_tried)
  );
`ifndef KEY_SEARCH_TIMEOUT_EN
  assign timed_out_w = 1'b0;
`endif

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: search phase tracked as "cycles until key is available", "run", "check pending"
  bit m_prev_start, m_prev_done, m_busy, m_kc, m_av, m_found, m_exh, m_to, m_check, m_mv;
  bit m_se, m_de;
  logic [KW-1:0] m_key, m_tried;
  int m_wait, m_run;

  always @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      m_prev_start = 0; m_prev_done = 0; m_busy = 0; m_kc = 0; m_av = 0;
      m_found = 0; m_exh = 0; m_to = 0; m_check = 0; m_mv = 0;
      m_key = KS; m_tried = '0; m_wait = 0; m_run = 0;
    end else begin
      m_se = start && !m_prev_start;
      m_de = decrypt_done && !m_prev_done;
      m_prev_start = start;
      m_prev_done = decrypt_done;
      m_kc = 0;
      if (abort) begin
        m_busy = 0; m_av = 0; m_found = 0; m_exh = 0; m_to = 0; m_check = 0; m_wait = 0;
      end else if (!m_busy) begin
        if (m_se) begin
          m_key = KS; m_tried = '0; m_found = 0; m_exh = 0; m_to = 0;
          m_busy = 1; m_kc = 1; m_wait = S; m_check = 0;
        end
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin m_av = 1; m_run = 0; end
      end else if (m_check) begin
        m_check = 0;
        m_tried = m_tried + 1'b1;
        if (m_mv) begin m_found = 1; m_busy = 0; end
        else if (m_key == KE) begin m_exh = 1; m_busy = 0; end
        else begin m_key = m_key + 1'b1; m_kc = 1; m_wait = S; end
      end else if (m_de) begin
        m_check = 1; m_mv = msg_valid; m_av = 0;
      end else begin
        m_run++;
        if (TO_EN && m_run == TO) begin m_to = 1; m_busy = 0; m_av = 0; end
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge CLOCK_50) begin
    chk("secret_key", 32'(secret_key), 32'(m_key));
    chk("keys_tried", 32'(keys_tried), 32'(m_tried));
    chk("key_changed", 32'(key_changed), 32'(m_kc));
    chk("key_available", 32'(key_available), 32'(m_av));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("found", 32'(found), 32'(m_found));
    chk("exhausted", 32'(exhausted), 32'(m_exh));
    chk("timed_out", 32'(timed_out_w), 32'(m_to));
    if (key_changed) kc_count++;
  end

  task automatic tick;
    @(posedge CLOCK_50);
    #2;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_kc"}, 32'(key_changed), 32'd0);
    chk({tag, "_av"}, 32'(key_available), 32'd0);
    chk({tag, "_found"}, 32'(found), 32'd0);
    chk({tag, "_exh"}, 32'(exhausted), 32'd0);
    chk({tag, "_key"}, 32'(secret_key), 32'(KS));
    chk({tag, "_tried"}, 32'(keys_tried), 32'd0);
    chk({tag, "_to"}, 32'(timed_out_w), 32'd0);
  endtask

  task automatic wait_avail(output bit ok);
    ok = 0;
    for (int n = 0; n < 50; n++) begin
      if (key_available) begin ok = 1; break; end
      tick;
    end
    if (!ok) chk("wait_key_available", 32'(key_available), 32'd1);
  endtask

  // Stand-in for time_machine: run a while, then raise done with the checker verdict
  task automatic serve_key(input int run_len, input logic [KW-1:0] good_key);
    bit ok;
    wait_avail(ok);
    if (!ok) return;
    repeat (run_len) tick;
    decrypt_done = 1'b1;
    msg_valid = (secret_key == good_key);
    tick;
    decrypt_done = 1'b0;
    msg_valid = 1'b0;
  endtask

  task automatic restart;
    start = 1'b0; tick;
    start = 1'b1;
  endtask

  initial begin
    bit ok, stall;
    #3 reset = 1'b1;
    #1 check_reset_vals("por");
    repeat (2) tick;
    reset = 1'b0;
    tick;

    // Found at key 2, with start-to-handshake timing
    kc_count = 0;
    start = 1'b1;
    tick; chk("t_kc_n1", 32'(key_changed), 32'd1); chk("t_busy_n1", 32'(busy), 32'd1);
    tick; chk("t_kc_n2", 32'(key_changed), 32'd0); chk("t_av_n2", 32'(key_available), 32'd0);
    tick; chk("t_av_n3", 32'(key_available), 32'd1);
    repeat (3) tick;
    decrypt_done = 1'b1;
    tick; decrypt_done = 1'b0;
    chk("t_check_kc", 32'(key_changed), 32'd0); chk("t_check_av", 32'(key_available), 32'd0);
    tick; chk("t_next_kc", 32'(key_changed), 32'd1); chk("t_next_key", 32'(secret_key), 32'd1);
    serve_key(2, 8'd2);
    serve_key(4, 8'd2);
    repeat (3) tick;
    chk("a_found", 32'(found), 32'd1); chk("a_key", 32'(secret_key), 32'd2);
    chk("a_tried", 32'(keys_tried), 32'd3); chk("a_busy", 32'(busy), 32'd0);
    chk("a_kc_pulses", 32'(kc_count), 32'd3);

    // Range exhausted
    restart; kc_count = 0;
    repeat (4) serve_key(2, 8'hFF);
    repeat (3) tick;
    chk("b_exh", 32'(exhausted), 32'd1); chk("b_key", 32'(secret_key), 32'd3);
    chk("b_tried", 32'(keys_tried), 32'd4); chk("b_found", 32'(found), 32'd0);
    chk("b_kc_pulses", 32'(kc_count), 32'd4);

    // Abort during RUN of key 1, then restart
    restart;
    serve_key(2, 8'hFF);
    wait_avail(ok);
    tick; abort = 1'b1;
    tick; abort = 1'b0;
    chk("c_busy", 32'(busy), 32'd0); chk("c_av", 32'(key_available), 32'd0);
    chk("c_key", 32'(secret_key), 32'd1); chk("c_exh", 32'(exhausted), 32'd0);
    restart;
    tick;
    chk("c_rs_key", 32'(secret_key), 32'd0); chk("c_rs_tried", 32'(keys_tried), 32'd0);
    chk("c_rs_kc", 32'(key_changed), 32'd1);
    abort = 1'b1; tick; abort = 1'b0;

    // decrypt_done already high when RUN begins
    restart;
    tick; decrypt_done = 1'b1;
    wait_avail(ok);
    repeat (3) tick;
    chk("d_held_tried", 32'(keys_tried), 32'd0); chk("d_held_av", 32'(key_available), 32'd1);
    decrypt_done = 1'b0;
    repeat (2) tick;
    decrypt_done = 1'b1;
    tick; decrypt_done = 1'b0;
    repeat (2) tick;
    chk("d_tried", 32'(keys_tried), 32'd1); chk("d_key", 32'(secret_key), 32'd1);
    abort = 1'b1; tick; abort = 1'b0;

`ifdef KEY_SEARCH_TIMEOUT_EN
    restart;
    wait_avail(ok);
    repeat (TO - 1) tick;
    chk("e_pre_to", 32'(timed_out_w), 32'd0);
    tick;
    chk("e_to", 32'(timed_out_w), 32'd1); chk("e_busy", 32'(busy), 32'd0);
    chk("e_key", 32'(secret_key), 32'(KS));
    restart;
    wait_avail(ok);
    tick;
    reset = 1'b1;
    #1 check_reset_vals("e_rst");
    tick; reset = 1'b0;
`endif

    // Random traffic
    start = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      tick;
      if (reset) begin
        reset = 1'b0;
        continue;
      end
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b1;
        #1 check_reset_vals("rand_rst");
        continue;
      end
      stall = ((i % 1000) >= 500) && ((i % 1000) < 650);
      if ($urandom_range(0, 7) == 0) start = ~start;
      abort = !stall && ($urandom_range(0, 47) == 0);
      if (stall) decrypt_done = 1'b0;
      else if ($urandom_range(0, 3) == 0) decrypt_done = ~decrypt_done;
      msg_valid = ($urandom_range(0, 5) == 0);
    end
    reset = 1'b0; abort = 1'b0; start = 1'b0; decrypt_done = 1'b0;
    repeat (3) tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL bench_watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
